cache_ctrl_fsm: RTL

Parametrised controller FSM for a direct-mapped, write-through cache, sitting between the CPU request interface and the cache data/tag arrays and main-memory bus. It replaces the fixed single-word controller, which used an external latency counter. This block adds an internal memory-latency counter and multi-word line refill. Write-allocate on write miss is a compile-time option.

---
 rtl/cache_ctrl_pkg.sv | 27 ++
 rtl/lat_counter.sv | 29 ++
 rtl/cache_ctrl_fsm.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types for the write-through cache controller: FSM state encoding,
// captured operation kind and memory-direction constants.
// No logic; imported by cache_ctrl_fsm.
package cache_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_READ       = 4'd1,
        S_WRITE      = 4'd2,
        S_FILL_REQ   = 4'd3,
        S_FILL_WAIT  = 4'd4,
        S_READ_DATA  = 4'd5,
        S_WRITE_HIT  = 4'd6,
        S_WRITE_MEM  = 4'd7,
        S_WRITE_WAIT = 4'd8,
        S_WRITE_DATA = 4'd9
    } state_t;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_t;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter used to time memory responses; zero flags expiry.
// Ports: clk, reset (sync, active-high), load/load_val, dec, zero.
// Decrement saturates at zero so a stray dec can never wrap.
module lat_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Controller FSM for a direct-mapped write-through cache with multi-word line
// refill and an internal memory-latency counter. Moore outputs from state.
// Ports: CPU side strobe/rw/rdy/busy, tag side hit/valid, array side w/wsel/
// rsel/word_idx, memory side mstrobe/mrw. Synchronous active-high reset.
// Optional: define WRITE_ALLOCATE_EN to refill the line on a write miss.
module cache_ctrl_fsm
    import cache_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int LINE_WORDS  = 4,
    parameter int CNT_W       = $clog2(MEM_LATENCY + 1),
    parameter int WIDX_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              strobe,
    input  logic              rw,
    input  logic              hit,
    input  logic              valid,
    output logic              rdy,
    output logic              busy,
    output logic              w,
    output logic              wsel,
    output logic              rsel,
    output logic              mstrobe,
    output logic              mrw,
    output logic [WIDX_W-1:0] word_idx
);

    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(LINE_WORDS - 1);
    // Counter starts at L-1 so the wait state lasts exactly L cycles.
    localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t state_q, state_d;
    op_t    op_q;
    logic   cnt_load, cnt_dec, cnt_zero;
    logic   widx_clr, widx_inc, op_cap;

    lat_counter #(.CNT_W(CNT_W)) u_lat (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (LAT_LOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_WRITE;
            word_idx <= '0;
        end else begin
            if (op_cap) begin
                op_q <= op_t'(rw);
            end
            if (widx_clr) begin
                word_idx <= '0;
            end else if (widx_inc) begin
                word_idx <= word_idx + WIDX_W'(1);
            end
        end
    end

    // The CPU always reads from the cache array; refill data lands there first.
    assign rsel = 1'b0;

    always_comb begin
        state_d  = state_q;
        rdy      = 1'b0;
        busy     = 1'b0;
        w        = 1'b0;
        wsel     = 1'b0;
        mstrobe  = 1'b0;
        mrw      = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        widx_clr = 1'b0;
        widx_inc = 1'b0;
        op_cap   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    op_cap  = 1'b1;
                    state_d = rw ? S_READ : S_WRITE;
                end
            end
            S_READ: begin
                busy = 1'b1;
                if (hit && valid) begin
                    state_d = S_READ_DATA;
                end else begin
                    widx_clr = 1'b1;
                    state_d  = S_FILL_REQ;
                end
            end
            S_WRITE: begin
                busy = 1'b1;
                if (hit && valid) begin
                    state_d = S_WRITE_HIT;
                end else begin
`ifdef WRITE_ALLOCATE_EN
                    widx_clr = 1'b1;
                    state_d  = S_FILL_REQ;
`else
                    state_d  = S_WRITE_MEM;
`endif
                end
            end
            S_FILL_REQ: begin
                busy     = 1'b1;
                mstrobe  = 1'b1;
                mrw      = MEM_RD;
                cnt_load = 1'b1;
                state_d  = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                busy = 1'b1;
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    w    = 1'b1;
                    wsel = 1'b1;
                    if (word_idx == LAST_IDX) begin
                        // A write-allocate fill finishes by merging the CPU word.
                        state_d = (op_q == OP_READ) ? S_READ_DATA : S_WRITE_HIT;
                    end else begin
                        widx_inc = 1'b1;
                        state_d  = S_FILL_REQ;
                    end
                end
            end
            S_READ_DATA: begin
                busy    = 1'b1;
                rdy     = 1'b1;
                state_d = S_IDLE;
            end
            S_WRITE_HIT: begin
                busy    = 1'b1;
                w       = 1'b1;
                wsel    = 1'b0;
                state_d = S_WRITE_MEM;
            end
            S_WRITE_MEM: begin
                busy     = 1'b1;
                mstrobe  = 1'b1;
                mrw      = MEM_WR;
                cnt_load = 1'b1;
                state_d  = S_WRITE_WAIT;
            end
            S_WRITE_WAIT: begin
                busy = 1'b1;
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    state_d = S_WRITE_DATA;
                end
            end
            S_WRITE_DATA: begin
                busy    = 1'b1;
                rdy     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
